// File: rtl/qspa_loop_stack.sv
// Nested hardware loop controller for the QSPA scalar front end.
// LCSET pushes {start_pc, count}; LOOP redirects fetch to the body start or retires the innermost loop.
module qspa_loop_stack #(
  parameter int PC_WIDTH    = 16,
  parameter int COUNT_WIDTH = 18,
  parameter int DEPTH       = 4,
  parameter int DEPTH_W     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   lc_valid,
  input  logic [COUNT_WIDTH-1:0] lc_count,
  input  logic [PC_WIDTH-1:0]    lc_start_pc,
  input  logic                   loop_valid,
  output logic                   redirect_valid,
  output logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   loop_active,
  output logic [DEPTH_W-1:0]     depth,
  output logic [COUNT_WIDTH-1:0] top_remaining,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_WIDTH-1:0]    stack_pc  [DEPTH];
  logic [COUNT_WIDTH-1:0] stack_rem [DEPTH];

  logic [DEPTH_W-1:0]     top_ptr, after_ptr, d_after_loop, depth_nxt;
  logic [IDX_W-1:0]       top_idx, after_idx, push_idx;
  logic                   dec, redir, underflow, push_ok, overflow;
  logic [COUNT_WIDTH-1:0] push_val, top_rem_nxt;

  assign top_ptr   = depth - 1'b1;
  assign top_idx   = top_ptr[IDX_W-1:0];
  assign after_ptr = d_after_loop - 1'b1;
  assign after_idx = after_ptr[IDX_W-1:0];
  assign push_idx  = d_after_loop[IDX_W-1:0];
  assign push_val  = (lc_count == '0) ? COUNT_WIDTH'(1) : lc_count;

  // LOOP resolves against the current top first; any push lands on the resulting stack.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    d_after_loop = depth;
    dec          = 1'b0;
    redir        = 1'b0;
    underflow    = 1'b0;
    if (loop_valid) begin
      if (depth == '0) begin
        underflow = 1'b1;
      end else if (top_remaining > COUNT_WIDTH'(1)) begin
        dec   = 1'b1;
        redir = 1'b1;
      end else begin
        d_after_loop = depth - 1'b1;
      end
    end

    push_ok   = lc_valid && (d_after_loop < DEPTH_W'(DEPTH));
    overflow  = lc_valid && !push_ok;
    depth_nxt = d_after_loop + DEPTH_W'(push_ok);

    if (push_ok)                  top_rem_nxt = push_val;
    else if (dec)                 top_rem_nxt = top_remaining - 1'b1;
    else if (d_after_loop == '0)  top_rem_nxt = '0;
    else                          top_rem_nxt = stack_rem[after_idx];
  end

  // NOTE: stack entries are not reset; depth alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (dec)     stack_rem[top_idx] <= top_remaining - 1'b1;
      if (push_ok) begin
        stack_rem[push_idx] <= push_val;
        stack_pc[push_idx]  <= lc_start_pc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      loop_active    <= 1'b0;
      depth          <= '0;
      top_remaining  <= '0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else if (flush) begin
      redirect_valid <= 1'b0;
      loop_active    <= 1'b0;
      depth          <= '0;
      top_remaining  <= '0;
    end else begin
      redirect_valid <= redir;
      if (redir) redirect_pc <= stack_pc[top_idx];
      loop_active    <= (depth_nxt != '0);
      depth          <= depth_nxt;
      top_remaining  <= top_rem_nxt;
      if (overflow)  err_overflow  <= 1'b1;
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/qspa_loop_stack.md
# qspa_loop_stack

Parametrised hardware loop controller for the QSPA scalar front end, succeeding the single-level LCSET/LOOP semantics with a configurable-depth nested loop stack. It sits beside the issue stage: LCSET_IMM/LCSET_REG push an iteration count and body start PC; LOOP either redirects fetch to the body start or retires the innermost loop. It drives FLAG_LOOP_ACTIVE (SR bit 6) and sticky error flags for stack misuse.

## Interface
- PC_WIDTH, 16, width of program counter values
- COUNT_WIDTH, 18, iteration count width (matches imm18)
- DEPTH, 4, maximum loop nesting (>= 1)
- DEPTH_W, $clog2(DEPTH+1), width of depth output

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all stack entries (pipeline flush / HALT)
- lc_valid  in  1  LCSET issued this cycle (push)
- lc_count  in  COUNT_WIDTH  iteration count
- lc_start_pc  in  PC_WIDTH  first PC of loop body
- loop_valid  in  1  LOOP instruction issued this cycle
- redirect_valid  out  1  one-cycle pulse: fetch must jump
- redirect_pc  out  PC_WIDTH  jump target, valid with redirect_valid
- loop_active  out  1  stack non-empty (FLAG_LOOP_ACTIVE)
- depth  out  DEPTH_W  current entry count
- top_remaining  out  COUNT_WIDTH  remaining iterations of innermost loop, 0 when empty
- err_overflow  out  1  sticky: push attempted while full
- err_underflow  out  1  sticky: LOOP issued while empty

## Operation
- Stack entries {start_pc, remaining}; top = most recent push.
- Push (lc_valid): remaining = lc_count, except lc_count == 0 stored as 1 (body always executes once).
- LOOP with non-empty stack:
  - remaining > 1: remaining -= 1, redirect_valid=1, redirect_pc=top.start_pc.
  - remaining == 1: pop, no redirect (fall through).
- LOOP with empty stack: no state change, no redirect, err_underflow set.
- Push while full (after any same-cycle pop): push dropped, err_overflow set, stack unchanged otherwise.
- Simultaneous lc_valid and loop_valid: LOOP evaluated against current top first, then push applied to resulting stack. Pop+push at full depth is legal (no overflow); decrement+push at full overflows.
- flush: highest priority; depth -> 0, same-cycle lc_valid/loop_valid ignored, no redirect; sticky errors retained.
- Sticky errors cleared only by rst.
- Arithmetic unsigned; remaining never wraps (decrement only when > 1).

## Timing
- All outputs registered; inputs sampled on rising clk.
- redirect_valid/redirect_pc: asserted in cycle N+1 for loop_valid in cycle N, single-cycle pulse; redirect_pc holds last value when redirect_valid=0.
- depth, loop_active, top_remaining reflect the update from cycle N's inputs in cycle N+1.
- Back-to-back LOOPs every cycle supported at full throughput.
- Reset values: redirect_valid=0, redirect_pc=0, loop_active=0, depth=0, top_remaining=0, err_overflow=0, err_underflow=0; all entries invalid.
- rst mid-loop: stack discarded next cycle, any pending redirect suppressed.

## Test plan
- Push count 3 start_pc 0x0040, issue LOOP x3 -> redirects to 0x0040 on first two (top_remaining 2 then 1), third pops, loop_active=0, depth=0.
- Nested: push (2,0x10), push (2,0x20), LOOP x4 -> redirects 0x20, pop inner, redirect 0x10, pop outer; depth 2,2,1,1,0.
- DEPTH=4: five pushes -> depth=4, err_overflow=1, top still fifth-push-dropped entry (4th values); then same-cycle pop(remaining 1)+push at full -> depth 4, no new error.
- LOOP on empty stack -> no redirect, err_underflow=1 sticky until rst; lc_count=0 push then LOOP -> immediate pop, no redirect.
- flush with depth 3 and concurrent loop_valid -> depth 0, no redirect, errors unchanged.
- rst asserted during cycle after LOOP with remaining 5 -> redirect_valid=0, all outputs at reset values next cycle.
